regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the next CPU generation; replaces the

---
 rtl/regfile_mp_pkg.sv | 23 ++
 rtl/regfile_mp_rdport.sv | 71 +++++++
 rtl/regfile_mp.sv | 106 ++++++++++
 tb/tb_regfile_mp.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_mp_pkg.sv
// ============================================================================
// Module      : regfile_mp_pkg
// Description : Shared CPU defaults, lane width and clog2 helper for regfile_mp.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_mp_pkg;

  localparam int CPU_WORD  = 16;
  localparam int CPU_NREGS = 16;
  localparam int LANE_W    = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_rdport.sv
// ============================================================================
// Module      : regfile_mp_rdport
// Description : One combinational read port with ready flag; write-data bypass
//               merge when REGFILE_BYPASS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter  int WIDTH = CPU_WORD,
  parameter  int NREGS = CPU_NREGS,
  localparam int AW    = clog2(NREGS),
  localparam int NB    = WIDTH / LANE_W
) (
  input  logic [WIDTH-1:0] regs [NREGS],
  input  logic [NREGS-1:0] pend,
  input  logic [AW-1:0]    addr,
  input  logic             wr_ok,
  input  logic [AW-1:0]    wr_addr,
  input  logic [NB-1:0]    wr_be,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  localparam logic [AW:0] c_nregs = (AW + 1)'(NREGS);

  logic             w_in_range;
  logic [WIDTH-1:0] w_stored;
  logic             w_pend;

  assign w_in_range = {1'b0, addr} < c_nregs;

  always_comb begin
    w_stored = '0;
    w_pend   = 1'b0;
    if (w_in_range) begin
      w_stored = regs[addr];
      w_pend   = pend[addr];
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_hit;

  // wr_ok already excludes out-of-range and hard-wired r0 targets
  assign w_hit = wr_ok && (addr == wr_addr);

  always_comb begin
    data = w_stored;
    if (w_hit) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) data[b*LANE_W +: LANE_W] = wr_data[b*LANE_W +: LANE_W];
      end
    end
  end

  assign ready = !w_pend || w_hit;
`else
  logic w_unused;

  assign w_unused = ^{wr_ok, wr_addr, wr_be, wr_data};
  assign data     = w_stored;
  assign ready    = !w_pend;
`endif

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : Multi-port byte-lane register file with per-register pending
//               scoreboard. Optional REGFILE_BYPASS_EN forwards write data.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter  int WIDTH   = CPU_WORD,
  parameter  int NREGS   = CPU_NREGS,
  parameter  int NREAD   = 3,
  parameter  int ZERO_R0 = 0,
  localparam int AW      = clog2(NREGS),
  localparam int CW      = clog2(NREGS + 1),
  localparam int NB      = WIDTH / LANE_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_ready,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [NB-1:0]          wr_be,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  output logic                   iss_ok,
  output logic [CW-1:0]          busy_cnt
);

  localparam logic [AW:0]   c_nregs = (AW + 1)'(NREGS);
  localparam logic [CW-1:0] c_max   = CW'(NREGS);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_pend_nxt;
  logic [CW-1:0]    r_busy;

  logic w_wr_in, w_wr_zero, w_wr_ok, w_wr_clr;
  logic w_iss_in, w_iss_zero, w_iss_acc;

  assign w_wr_in    = {1'b0, wr_addr} < c_nregs;
  assign w_wr_zero  = (ZERO_R0 != 0) && (wr_addr == '0);
  assign w_wr_ok    = wr_en && w_wr_in && !w_wr_zero;
  assign w_wr_clr   = w_wr_ok && r_pend[wr_addr];

  // A hard-wired r0 always reports free but never takes a reservation
  assign w_iss_in   = {1'b0, iss_addr} < c_nregs;
  assign w_iss_zero = (ZERO_R0 != 0) && (iss_addr == '0);
  assign iss_ok     = w_iss_in && (w_iss_zero || !r_pend[iss_addr]);
  assign w_iss_acc  = iss_en && iss_ok && !w_iss_zero;

  always_comb begin
    w_pend_nxt = r_pend;
    if (w_wr_ok)   w_pend_nxt[wr_addr]  = 1'b0;
    if (w_iss_acc) w_pend_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_pend <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        for (int b = 0; b < NB; b++) begin
          if (wr_be[b]) r_regs[wr_addr][b*LANE_W +: LANE_W] <= wr_data[b*LANE_W +: LANE_W];
        end
      end
      r_pend <= w_pend_nxt;
      // Simultaneous reserve and release cancel out
      if (w_iss_acc && !w_wr_clr && (r_busy != c_max))
        r_busy <= r_busy + CW'(1);
      else if (w_wr_clr && !w_iss_acc && (r_busy != '0))
        r_busy <= r_busy - CW'(1);
    end
  end

  assign busy_cnt = r_busy;

  generate
    for (genvar p = 0; p < NREAD; p++) begin : g_rdport
      regfile_mp_rdport #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
      ) u_rdport (
        .regs    (r_regs),
        .pend    (r_pend),
        .addr    (rd_addr[p*AW +: AW]),
        .wr_ok   (w_wr_ok),
        .wr_addr (wr_addr),
        .wr_be   (wr_be),
        .wr_data (wr_data),
        .data    (rd_data[p*WIDTH +: WIDTH]),
        .ready   (rd_ready[p])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module      : tb_regfile_mp
// Description : Directed self-checking bench for regfile_mp (default, ZERO_R0
//               and 12-register instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // a_: 16 regs, z_: 16 regs with hard-wired r0, n_: 12 regs
  logic [11:0] a_rd_addr, z_rd_addr, n_rd_addr;
  logic [47:0] a_rd_data, z_rd_data, n_rd_data;
  logic [2:0]  a_rd_ready, z_rd_ready, n_rd_ready;
  logic        a_wr_en, z_wr_en, n_wr_en;
  logic [3:0]  a_wr_addr, z_wr_addr, n_wr_addr;
  logic [1:0]  a_wr_be, z_wr_be, n_wr_be;
  logic [15:0] a_wr_data, z_wr_data, n_wr_data;
  logic        a_iss_en, z_iss_en, n_iss_en;
  logic [3:0]  a_iss_addr, z_iss_addr, n_iss_addr;
  logic        a_iss_ok, z_iss_ok, n_iss_ok;
  logic [4:0]  a_busy, z_busy;
  logic [3:0]  n_busy;

  int n_cmp = 0;
  int n_err = 0;

  regfile_mp #(.WIDTH(16), .NREGS(16), .NREAD(3), .ZERO_R0(0)) u_dut_a (
    .clk(clk), .reset(reset), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_ready(a_rd_ready), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_be(a_wr_be),
    .wr_data(a_wr_data), .iss_en(a_iss_en), .iss_addr(a_iss_addr),
    .iss_ok(a_iss_ok), .busy_cnt(a_busy)
  );

  regfile_mp #(.WIDTH(16), .NREGS(16), .NREAD(3), .ZERO_R0(1)) u_dut_z (
    .clk(clk), .reset(reset), .rd_addr(z_rd_addr), .rd_data(z_rd_data),
    .rd_ready(z_rd_ready), .wr_en(z_wr_en), .wr_addr(z_wr_addr), .wr_be(z_wr_be),
    .wr_data(z_wr_data), .iss_en(z_iss_en), .iss_addr(z_iss_addr),
    .iss_ok(z_iss_ok), .busy_cnt(z_busy)
  );

  regfile_mp #(.WIDTH(16), .NREGS(12), .NREAD(3), .ZERO_R0(0)) u_dut_n (
    .clk(clk), .reset(reset), .rd_addr(n_rd_addr), .rd_data(n_rd_data),
    .rd_ready(n_rd_ready), .wr_en(n_wr_en), .wr_addr(n_wr_addr), .wr_be(n_wr_be),
    .wr_data(n_wr_data), .iss_en(n_iss_en), .iss_addr(n_iss_addr),
    .iss_ok(n_iss_ok), .busy_cnt(n_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_wr_en = 0; a_wr_addr = 0; a_wr_be = 0; a_wr_data = 0; a_iss_en = 0; a_iss_addr = 0;
    z_wr_en = 0; z_wr_addr = 0; z_wr_be = 0; z_wr_data = 0; z_iss_en = 0; z_iss_addr = 0;
    n_wr_en = 0; n_wr_addr = 0; n_wr_be = 0; n_wr_data = 0; n_iss_en = 0; n_iss_addr = 0;
    a_rd_addr = 0; z_rd_addr = 0; n_rd_addr = 0;
  endtask

  task automatic a_write(input logic [3:0] ad, input logic [1:0] be, input logic [15:0] d);
    a_wr_en = 1; a_wr_addr = ad; a_wr_be = be; a_wr_data = d;
    tick();
    a_wr_en = 0;
  endtask

  task automatic a_issue(input logic [3:0] ad);
    a_iss_en = 1; a_iss_addr = ad;
    tick();
    a_iss_en = 0;
  endtask

  task automatic test_reset();
    reset = 0;
    a_write(4'd1, 2'b11, 16'h5555);
    a_issue(4'd4);
    // reset must beat a same-cycle write and issue
    reset = 1;
    a_wr_en = 1; a_wr_addr = 4'd1; a_wr_be = 2'b11; a_wr_data = 16'hFFFF;
    a_iss_en = 1; a_iss_addr = 4'd6;
    tick();
    reset = 0;
    idle_all();
    a_rd_addr = {4'd6, 4'd4, 4'd1};
    a_iss_addr = 4'd4;
    #1;
    n_cmp++;
    if (a_rd_data !== 48'h0) begin
      n_err++; $display("FAIL reset_rd_data got %h want %h", a_rd_data, 48'h0);
    end
    n_cmp++;
    if (a_rd_ready !== 3'b111) begin
      n_err++; $display("FAIL reset_rd_ready got %b want %b", a_rd_ready, 3'b111);
    end
    n_cmp++;
    if (a_busy !== 5'd0) begin
      n_err++; $display("FAIL reset_busy got %0d want 0", a_busy);
    end
    n_cmp++;
    if (a_iss_ok !== 1'b1) begin
      n_err++; $display("FAIL reset_iss_ok got %b want 1", a_iss_ok);
    end
  endtask

  task automatic test_byte_lanes();
    a_write(4'd5, 2'b01, 16'hBEEF);
    a_rd_addr = {4'd0, 4'd0, 4'd5};
    #1;
    n_cmp++;
    if (a_rd_data[15:0] !== 16'h00EF) begin
      n_err++; $display("FAIL lane_low got %h want %h", a_rd_data[15:0], 16'h00EF);
    end
    a_write(4'd5, 2'b10, 16'h1234);
    #1;
    n_cmp++;
    if (a_rd_data[15:0] !== 16'h12EF) begin
      n_err++; $display("FAIL lane_high got %h want %h", a_rd_data[15:0], 16'h12EF);
    end
  endtask

  task automatic test_scoreboard();
    a_issue(4'd3);
    a_rd_addr = {4'd0, 4'd0, 4'd3};
    a_iss_addr = 4'd3;
    #1;
    n_cmp++;
    if (a_rd_ready[0] !== 1'b0) begin
      n_err++; $display("FAIL pend_ready got %b want 0", a_rd_ready[0]);
    end
    n_cmp++;
    if (a_iss_ok !== 1'b0) begin
      n_err++; $display("FAIL pend_iss_ok got %b want 0", a_iss_ok);
    end
    n_cmp++;
    if (a_busy !== 5'd1) begin
      n_err++; $display("FAIL pend_busy got %0d want 1", a_busy);
    end
    a_issue(4'd3);
    n_cmp++;
    if (a_busy !== 5'd1) begin
      n_err++; $display("FAIL reissue_busy got %0d want 1", a_busy);
    end
    a_write(4'd3, 2'b11, 16'h0042);
    #1;
    n_cmp++;
    if (a_rd_ready[0] !== 1'b1) begin
      n_err++; $display("FAIL wb_ready got %b want 1", a_rd_ready[0]);
    end
    n_cmp++;
    if (a_busy !== 5'd0) begin
      n_err++; $display("FAIL wb_busy got %0d want 0", a_busy);
    end
    n_cmp++;
    if (a_rd_data[15:0] !== 16'h0042) begin
      n_err++; $display("FAIL wb_data got %h want %h", a_rd_data[15:0], 16'h0042);
    end
  endtask

  task automatic test_wr_issue_same_cycle();
    a_issue(4'd7);
    a_wr_en = 1; a_wr_addr = 4'd7; a_wr_be = 2'b11; a_wr_data = 16'h7777;
    a_iss_en = 1; a_iss_addr = 4'd9;
    tick();
    a_wr_en = 0; a_iss_en = 0;
    a_rd_addr = {4'd0, 4'd7, 4'd9};
    #1;
    n_cmp++;
    if (a_busy !== 5'd1) begin
      n_err++; $display("FAIL mixed_busy got %0d want 1", a_busy);
    end
    n_cmp++;
    if (a_rd_ready[1:0] !== 2'b10) begin
      n_err++; $display("FAIL mixed_ready got %b want %b", a_rd_ready[1:0], 2'b10);
    end
    n_cmp++;
    if (a_rd_data[31:16] !== 16'h7777) begin
      n_err++; $display("FAIL mixed_data got %h want %h", a_rd_data[31:16], 16'h7777);
    end
    a_write(4'd9, 2'b00, 16'hFFFF);
    // same register written and re-reserved in one cycle
    a_wr_en = 1; a_wr_addr = 4'd6; a_wr_be = 2'b11; a_wr_data = 16'h6666;
    a_iss_en = 1; a_iss_addr = 4'd6;
    tick();
    a_wr_en = 0; a_iss_en = 0;
    a_rd_addr = {4'd0, 4'd9, 4'd6};
    #1;
    n_cmp++;
    if (a_busy !== 5'd1) begin
      n_err++; $display("FAIL same_addr_busy got %0d want 1", a_busy);
    end
    n_cmp++;
    if (a_rd_ready[1:0] !== 2'b10) begin
      n_err++; $display("FAIL same_addr_ready got %b want %b", a_rd_ready[1:0], 2'b10);
    end
    n_cmp++;
    if (a_rd_data[31:0] !== 32'h0000_6666) begin
      n_err++; $display("FAIL same_addr_data got %h want %h", a_rd_data[31:0], 32'h0000_6666);
    end
    a_write(4'd6, 2'b00, 16'hFFFF);
    #1;
    n_cmp++;
    if ({a_busy, a_rd_ready[0], a_rd_data[15:0]} !== {5'd0, 1'b1, 16'h6666}) begin
      n_err++; $display("FAIL release_nodata got %h want %h",
                        {a_busy, a_rd_ready[0], a_rd_data[15:0]}, {5'd0, 1'b1, 16'h6666});
    end
  endtask

  task automatic test_bypass();
    logic [15:0] exp_data;
    logic        exp_ready;
    a_issue(4'd2);
    a_rd_addr = {4'd2, 4'd0, 4'd0};
    a_wr_en = 1; a_wr_addr = 4'd2; a_wr_be = 2'b11; a_wr_data = 16'hA5A5;
    #1;
`ifdef REGFILE_BYPASS_EN
    exp_data  = 16'hA5A5;
    exp_ready = 1'b1;
`else
    exp_data  = 16'h0000;
    exp_ready = 1'b0;
`endif
    n_cmp++;
    if (a_rd_data[47:32] !== exp_data) begin
      n_err++; $display("FAIL bypass_data got %h want %h", a_rd_data[47:32], exp_data);
    end
    n_cmp++;
    if (a_rd_ready[2] !== exp_ready) begin
      n_err++; $display("FAIL bypass_ready got %b want %b", a_rd_ready[2], exp_ready);
    end
    tick();
    a_wr_en = 0;
    #1;
    n_cmp++;
    if ({a_rd_ready[2], a_rd_data[47:32], a_busy} !== {1'b1, 16'hA5A5, 5'd0}) begin
      n_err++; $display("FAIL post_write got %h want %h",
                        {a_rd_ready[2], a_rd_data[47:32], a_busy}, {1'b1, 16'hA5A5, 5'd0});
    end
  endtask

  task automatic test_zero_r0();
    z_wr_en = 1; z_wr_addr = 4'd0; z_wr_be = 2'b11; z_wr_data = 16'hFFFF;
    z_iss_en = 1; z_iss_addr = 4'd0;
    z_rd_addr = 12'h0;
    #1;
    n_cmp++;
    if (z_iss_ok !== 1'b1) begin
      n_err++; $display("FAIL r0_iss_ok got %b want 1", z_iss_ok);
    end
    tick();
    z_wr_en = 0; z_iss_en = 0;
    #1;
    n_cmp++;
    if ({z_rd_data[15:0], z_rd_ready[0], z_busy} !== {16'h0000, 1'b1, 5'd0}) begin
      n_err++; $display("FAIL r0_const got %h want %h",
                        {z_rd_data[15:0], z_rd_ready[0], z_busy}, {16'h0000, 1'b1, 5'd0});
    end
    z_iss_en = 1; z_iss_addr = 4'd1;
    tick();
    z_iss_en = 0;
    n_cmp++;
    if (z_busy !== 5'd1) begin
      n_err++; $display("FAIL r1_issue_busy got %0d want 1", z_busy);
    end
  endtask

  task automatic test_narrow();
    n_rd_addr = {4'd0, 4'd0, 4'd13};
    n_iss_addr = 4'd13;
    #1;
    n_cmp++;
    if ({n_rd_data[15:0], n_rd_ready[0], n_iss_ok} !== {16'h0000, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL oor_read got %h want %h",
                        {n_rd_data[15:0], n_rd_ready[0], n_iss_ok}, {16'h0000, 1'b1, 1'b0});
    end
    n_iss_en = 1;
    n_wr_en = 1; n_wr_addr = 4'd13; n_wr_be = 2'b11; n_wr_data = 16'hDEAD;
    tick();
    n_iss_en = 0; n_wr_en = 0;
    n_cmp++;
    if ({n_busy, n_rd_data[15:0]} !== {4'd0, 16'h0000}) begin
      n_err++; $display("FAIL oor_ignored got %h want %h", {n_busy, n_rd_data[15:0]}, {4'd0, 16'h0000});
    end
    for (int i = 0; i < 12; i++) begin
      n_iss_en = 1; n_iss_addr = 4'(i);
      tick();
    end
    n_iss_en = 0;
    n_cmp++;
    if (n_busy !== 4'd12) begin
      n_err++; $display("FAIL fill_busy got %0d want 12", n_busy);
    end
    n_iss_en = 1; n_iss_addr = 4'd11;
    #1;
    n_cmp++;
    if (n_iss_ok !== 1'b0) begin
      n_err++; $display("FAIL full_iss_ok got %b want 0", n_iss_ok);
    end
    tick();
    n_iss_en = 0;
    n_cmp++;
    if (n_busy !== 4'd12) begin
      n_err++; $display("FAIL full_busy_hold got %0d want 12", n_busy);
    end
    n_wr_en = 1; n_wr_addr = 4'd0; n_wr_be = 2'b11; n_wr_data = 16'h1111;
    tick();
    n_wr_en = 0;
    n_rd_addr = {4'd0, 4'd0, 4'd0};
    #1;
    n_cmp++;
    if ({n_busy, n_rd_ready[0], n_rd_data[15:0]} !== {4'd11, 1'b1, 16'h1111}) begin
      n_err++; $display("FAIL r0_release got %h want %h",
                        {n_busy, n_rd_ready[0], n_rd_data[15:0]}, {4'd11, 1'b1, 16'h1111});
    end
  endtask

  initial begin
    idle_all();
    reset = 1;
    tick();
    tick();
    test_reset();
    test_byte_lanes();
    test_scoreboard();
    test_wr_issue_same_cycle();
    test_bypass();
    test_zero_r0();
    test_narrow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
